dsp_mac_8bit_seq: RTL and testbench
===================================

Name: dsp_mac_8bit_seq

Overview:
- Initiator and sequencer for the dsp_mac_8bit hard-DSP MAC (sum of two 8x8 products with accumulate, 27-bit result).
- Accepts a valid/ready stream of operand quadruples grouped into dot-product vectors by a last flag.
- Drives the DSP operand, accumulate, ena and aclr pins, tracks the DSP pipeline latency, and captures one accumulated 27-bit result per vector into a 2-entry output buffer with valid/ready.

Parameters:
- DSP_LAT, 3, clock-enabled cycles from operand presentation to the matching resulta update (input reg + pipeline + output reg); legal 1..8.
- RES_W, 27, result width; must equal the DSP resulta width.

Ports:
- clk0  in  1  block clock; the DSP clk0/1/2 are tied to the same net at top level.
- aclr0_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand quadruple valid.
- in_ready  out  1  block accepts the quadruple this cycle.
- in_ax, in_bx, in_ay, in_by  in  8 each  operands; product pairs are ax*bx and ay*by.
- in_last  in  1  final quadruple of the current vector.
- dsp_ax, dsp_bx, dsp_ay, dsp_by  out  8 each  to DSP.
- dsp_accumulate  out  1  to DSP accumulate.
- dsp_ena  out  3  to DSP ena; all bits are identical.
- dsp_aclr  out  1  to DSP aclr0/aclr1 (active high) = ~aclr0_n.
- dsp_resulta  in  RES_W  from DSP resulta.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  RES_W  accumulated dot product (ax*bx + ay*by summed over the vector, DSP arithmetic).

Behaviour:
- Reset: all state is cleared asynchronously on aclr0_n low.
  - Reset values: in_ready=0, out_valid=0, out_data=0, dsp_* operands=0, dsp_accumulate=0, dsp_ena=0, dsp_aclr=1.
  - Any vector in flight is discarded; the DSP is cleared via dsp_aclr.
- advance = !buf_full, where buf_full is registered buffer state. There is no combinational path from out_ready to in_ready.
  - dsp_ena = {3{advance}} and in_ready = advance.
- On each advance cycle:
  - If in_valid is high, the quadruple is presented to the DSP.
  - Otherwise a bubble is presented: operands 0, accumulate=1. Adding zero preserves the running sum.
- dsp_accumulate = 0 for the first quadruple of a vector (after reset or after a quadruple with last=1), and 1 otherwise.
- Operand and accumulate outputs are combinational from the input stream. The DSP's own input registers capture them.
- Tag pipeline: a DSP_LAT-deep shift register of {valid, last}. It shifts only on advance, so it stays aligned with the DSP pipeline, which freezes when ena=0.
  - When a tag with valid&last exits, dsp_resulta is pushed into the buffer in that same cycle.
- Output buffer: 2 entries, FIFO order. out_data shows the head; out_valid = not empty.
  - A pop happens on out_valid & out_ready. A push and a pop in the same cycle are both honoured.
  - Push is only possible on advance, so the buffer never overflows.
- Single-quadruple vectors (first quadruple has last=1) are legal and produce ax*bx + ay*by.
- Overflow wraps modulo 2^RES_W inside the DSP. Signedness is set by the DSP configuration; this block is agnostic.
- Latency: the result appears on out_valid DSP_LAT+1 advance cycles after the last quadruple is accepted (DSP_LAT cycles through the DSP, plus 1 for the buffer register).

Optional Feature:
- Macro: DSP_MAC_SEQ_PERF_EN.
- When defined, adds two outputs:
  - perf_vec_cnt [31:0]: increments on each buffer push.
  - perf_stall_cnt [31:0]: increments each cycle in_valid=1 and in_ready=0.
  - Both wrap, and both reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package dsp_mac_seq_pkg: OPD_W=8, RES_W=27, DSP_LAT_DEF=3, and the tag typedef struct {valid, last}.
- One natural sub-module: dsp_mac_seq_obuf, the 2-entry result FIFO (push, pop, full, empty, head).

Test Plan:
- Vector of 4 quadruples (ax,bx,ay,by)=(1,2,3,4),(5,6,7,8),(2,2,2,2),(0,9,9,0), out_ready=1, DSP_LAT=3 -> one out_data=14+86+8+0=108, DSP_LAT+1 cycles after the last accept; accumulate sequence 0,1,1,1.
- Single-quadruple vectors back-to-back (10,10,1,1) then (3,3,3,3) -> out_data 101 then 18, each with accumulate=0.
- in_valid de-asserted for 5 cycles mid-vector -> bubbles leave the sum unchanged; the result equals the no-gap result.
- out_ready=0 while 3 vectors complete -> buffer fills to 2 and in_ready drops; dsp_ena=000 and the third result is held in the DSP. Release out_ready -> results arrive in order with none lost.
- aclr0_n pulsed low mid-vector -> dsp_aclr=1 and out_valid=0 immediately. The next vector (1,1,1,1) yields 2, with no residue.
- PERF_EN build with 5 stalled cycles and 3 vectors -> perf_stall_cnt=5, perf_vec_cnt=3.

Source files
------------

// File: rtl/dsp_mac_seq_pkg.sv
// Shared constants and types for the dsp_mac_8bit sequencer.
//   OPD_W       : operand width presented to the DSP
//   RES_W       : DSP resulta width
//   DSP_LAT_DEF : default clock-enabled latency from operand presentation to resulta update
//   tag_t       : per-slot bookkeeping that travels alongside the DSP pipeline
package dsp_mac_seq_pkg;

  localparam int unsigned OPD_W       = 8;
  localparam int unsigned RES_W       = 27;
  localparam int unsigned DSP_LAT_DEF = 3;

  typedef struct packed {
    logic valid;  // slot carried a real quadruple (not a bubble)
    logic last;   // that quadruple closed its vector
  } tag_t;

endpackage

// File: rtl/dsp_mac_8bit_seq_if.sv
// Operand-stream and result-stream bundle for dsp_mac_8bit_seq.
//   in_valid/in_ready           : operand quadruple handshake
//   in_ax/in_bx/in_ay/in_by     : operands, products are ax*bx and ay*by
//   in_last                     : final quadruple of the current vector
//   out_valid/out_ready         : result handshake
//   out_data                    : accumulated dot product of one vector
// Modports: master drives operands and consumes results, slave is the sequencer.
interface dsp_mac_8bit_seq_if #(
  parameter int unsigned RES_W = dsp_mac_seq_pkg::RES_W
);
  import dsp_mac_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPD_W-1:0] in_ax;
  logic [OPD_W-1:0] in_bx;
  logic [OPD_W-1:0] in_ay;
  logic [OPD_W-1:0] in_by;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_ax,
    output in_bx,
    output in_ay,
    output in_by,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_ax,
    input  in_bx,
    input  in_ay,
    input  in_by,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_data
  );

endinterface

// File: rtl/dsp_mac_seq_obuf.sv
// Two-entry FIFO holding completed dot-product results.
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write one result (ignored when full)
//   pop        : discard the head (ignored when empty)
//   full/empty : occupancy flags, both registered
//   head       : oldest stored result, zero after reset
// Simultaneous push and pop are both honoured.
module dsp_mac_seq_obuf
  import dsp_mac_seq_pkg::*;
#(
  parameter int unsigned WIDTH = RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dsp_mac_8bit_seq.sv
// Initiator/sequencer for the dsp_mac_8bit hard-DSP MAC.
// Streams operand quadruples into the DSP, drives accumulate/ena/aclr, follows the DSP
// pipeline with a tag shift register and captures one result per vector into a 2-entry
// output FIFO.
//   clk0, aclr0_n   : clock (shared with the DSP clocks) and async active-low reset
//   bus (slave)     : operand stream in, result stream out
//   dsp_ax..dsp_by  : operands to the DSP
//   dsp_accumulate  : 0 on the first quadruple of a vector, 1 otherwise (and on bubbles)
//   dsp_ena         : DSP clock enables, all bits equal
//   dsp_aclr        : DSP clear, active high
//   dsp_resulta     : DSP accumulated result
// Optional build macro DSP_MAC_SEQ_PERF_EN adds perf_vec_cnt and perf_stall_cnt.
// DSP_LAT legal range is 1..8.
module dsp_mac_8bit_seq #(
  parameter int unsigned DSP_LAT = dsp_mac_seq_pkg::DSP_LAT_DEF,
  parameter int unsigned RES_W   = dsp_mac_seq_pkg::RES_W
) (
  input  logic                              clk0,
  input  logic                              aclr0_n,
  dsp_mac_8bit_seq_if.slave                 bus,
  output logic [dsp_mac_seq_pkg::OPD_W-1:0] dsp_ax,
  output logic [dsp_mac_seq_pkg::OPD_W-1:0] dsp_bx,
  output logic [dsp_mac_seq_pkg::OPD_W-1:0] dsp_ay,
  output logic [dsp_mac_seq_pkg::OPD_W-1:0] dsp_by,
  output logic                              dsp_accumulate,
  output logic [2:0]                        dsp_ena,
  output logic                              dsp_aclr,
  input  logic [RES_W-1:0]                  dsp_resulta
`ifdef DSP_MAC_SEQ_PERF_EN
  ,
  output logic [31:0]                       perf_vec_cnt,
  output logic [31:0]                       perf_stall_cnt
`endif
);
  import dsp_mac_seq_pkg::*;

  tag_t tag_q [DSP_LAT];
  tag_t tag_in;
  tag_t tag_out;
  logic advance;
  logic accept;
  logic first_q;
  logic push;
  logic pop;
  logic buf_full;
  logic buf_empty;

  // The DSP and the tag pipe move only when the buffer can take a result, so a result
  // leaving the DSP always has a free slot. Held low during reset so nothing is accepted.
  assign advance      = aclr0_n & ~buf_full;
  assign accept       = advance & bus.in_valid;
  assign bus.in_ready = advance;
  assign dsp_ena      = {3{advance}};
  assign dsp_aclr     = ~aclr0_n;

  // Idle slots become zero-operand bubbles with accumulate set, which leaves the sum alone.
  always_comb begin
    dsp_ax         = '0;
    dsp_bx         = '0;
    dsp_ay         = '0;
    dsp_by         = '0;
    dsp_accumulate = 1'b0;
    if (aclr0_n) begin
      if (bus.in_valid) begin
        dsp_ax         = bus.in_ax;
        dsp_bx         = bus.in_bx;
        dsp_ay         = bus.in_ay;
        dsp_by         = bus.in_by;
        dsp_accumulate = ~first_q;
      end else begin
        dsp_accumulate = 1'b1;
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = bus.in_valid;
    tag_in.last  = bus.in_valid & bus.in_last;
  end

  always_ff @(posedge clk0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      for (int i = 0; i < DSP_LAT; i++) begin
        tag_q[i] <= '0;
      end
      first_q <= 1'b1;
    end else begin
      if (advance) begin
        tag_q[0] <= tag_in;
        for (int i = 1; i < DSP_LAT; i++) begin
          tag_q[i] <= tag_q[i-1];
        end
      end
      if (accept) begin
        first_q <= bus.in_last;
      end
    end
  end

  // A tag sitting in the final stage lines up with the resulta it describes.
  assign tag_out = tag_q[DSP_LAT-1];
  assign push    = advance & tag_out.valid & tag_out.last;
  assign pop     = bus.out_valid & bus.out_ready;

  dsp_mac_seq_obuf #(
    .WIDTH (RES_W)
  ) u_obuf (
    .clk   (clk0),
    .rst_n (aclr0_n),
    .push  (push),
    .din   (dsp_resulta),
    .pop   (pop),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (bus.out_data)
  );

  assign bus.out_valid = ~buf_empty;

`ifdef DSP_MAC_SEQ_PERF_EN
  logic [31:0] vec_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) begin
        vec_cnt_q <= vec_cnt_q + 32'd1;
      end
      if (bus.in_valid & ~advance) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_vec_cnt   = vec_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_mac_8bit_seq.sv
// Bench for dsp_mac_8bit_seq with a behavioural model of the external DSP and a
// dot-product reference computed directly from the stimulus.
module tb_dsp_mac_8bit_seq;

  localparam int unsigned DSP_LAT = 3;
  localparam int unsigned RES_W   = 27;

  logic clk0 = 1'b0;
  logic aclr0_n;
  always #5 clk0 = ~clk0;

  dsp_mac_8bit_seq_if #(.RES_W(RES_W)) bus ();

  logic [7:0]       dsp_ax, dsp_bx, dsp_ay, dsp_by;
  logic             dsp_accumulate;
  logic [2:0]       dsp_ena;
  logic             dsp_aclr;
  logic [RES_W-1:0] dsp_resulta;
`ifdef DSP_MAC_SEQ_PERF_EN
  logic [31:0]      perf_vec_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  dsp_mac_8bit_seq #(
    .DSP_LAT (DSP_LAT),
    .RES_W   (RES_W)
  ) dut (
    .clk0           (clk0),
    .aclr0_n        (aclr0_n),
    .bus            (bus),
    .dsp_ax         (dsp_ax),
    .dsp_bx         (dsp_bx),
    .dsp_ay         (dsp_ay),
    .dsp_by         (dsp_by),
    .dsp_accumulate (dsp_accumulate),
    .dsp_ena        (dsp_ena),
    .dsp_aclr       (dsp_aclr),
    .dsp_resulta    (dsp_resulta)
`ifdef DSP_MAC_SEQ_PERF_EN
    ,
    .perf_vec_cnt   (perf_vec_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int drv_timeout = 0;

  // out_ready source: 0 = low, 1 = high, 2 = random per cycle
  logic [1:0] rdy_mode;
  logic       rnd_bit = 1'b1;
  assign bus.out_ready = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];
  always @(negedge clk0) rnd_bit <= 1'($urandom_range(0, 1));

  always @(posedge clk0) cyc <= cyc + 1;

  // External DSP: DSP_LAT enabled edges from operands to resulta, frozen when ena is low.
  logic [RES_W:0]   dsp_pipe [$];  // {accumulate, product sum}
  logic [RES_W:0]   dsp_stage;
  logic [RES_W-1:0] dsp_prod;
  always @(posedge clk0 or posedge dsp_aclr) begin
    if (dsp_aclr) begin
      dsp_pipe.delete();
      for (int i = 0; i < int'(DSP_LAT) - 1; i++) dsp_pipe.push_back('0);
      dsp_resulta <= '0;
    end else if (dsp_ena[0]) begin
      dsp_prod = RES_W'(dsp_ax) * RES_W'(dsp_bx) + RES_W'(dsp_ay) * RES_W'(dsp_by);
      dsp_pipe.push_back({dsp_accumulate, dsp_prod});
      dsp_stage = dsp_pipe.pop_front();
      dsp_resulta <= dsp_stage[RES_W] ? dsp_resulta + dsp_stage[RES_W-1:0]
                                      : dsp_stage[RES_W-1:0];
    end
  end

  // Record every result handshake and every accepted quadruple.
  logic [RES_W-1:0] got_q [$];
  int               got_cyc [$];
  logic             acc_q [$];
  int               acc_cyc [$];
  always begin
    @(negedge clk0);
    #1;
    if (aclr0_n === 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got_q.push_back(bus.out_data);
        got_cyc.push_back(cyc);
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        acc_q.push_back(dsp_accumulate);
        acc_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [RES_W-1:0] quad_prod(input logic [7:0] ax, bx, ay, by);
    return RES_W'(ax) * RES_W'(bx) + RES_W'(ay) * RES_W'(by);
  endfunction

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    acc_q.delete();
    acc_cyc.delete();
  endtask

  task automatic drive_quad(input logic [7:0] ax, bx, ay, by, input logic last);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_ax = ax; bus.in_bx = bx; bus.in_ay = ay; bus.in_by = by;
    bus.in_last = last;
    while (bus.in_ready !== 1'b1 && w < 200) begin @(negedge clk0); w++; end
    if (w >= 200) drv_timeout++;
    @(negedge clk0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int w = 0;
    while (got_q.size() < n && w < budget) begin @(negedge clk0); w++; end
  endtask

  task automatic test_reset();
    aclr0_n = 1'b0;
    rdy_mode = 2'd1;
    bus.in_valid = 1'b1;
    bus.in_ax = 8'hAA; bus.in_bx = 8'h55; bus.in_ay = 8'h0F; bus.in_by = 8'hF0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++;
      $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    n_checks++; if ({dsp_ax, dsp_bx, dsp_ay, dsp_by} !== 32'h0) begin n_fail++;
      $display("FAIL reset_operands got=%h exp=0", {dsp_ax, dsp_bx, dsp_ay, dsp_by}); end
    n_checks++; if (dsp_accumulate !== 1'b0) begin n_fail++;
      $display("FAIL reset_accumulate got=%b exp=0", dsp_accumulate); end
    n_checks++; if (dsp_ena !== 3'b000) begin n_fail++;
      $display("FAIL reset_ena got=%b exp=000", dsp_ena); end
    n_checks++; if (dsp_aclr !== 1'b1) begin n_fail++;
      $display("FAIL reset_aclr got=%b exp=1", dsp_aclr); end
    bus.in_valid = 1'b0;
    aclr0_n = 1'b1;
    @(negedge clk0);
    n_checks++; if (bus.in_ready !== 1'b1 || dsp_ena !== 3'b111) begin n_fail++;
      $display("FAIL post_reset_advance in_ready=%b ena=%b exp 1/111", bus.in_ready, dsp_ena); end
    n_checks++; if (dsp_aclr !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_aclr got=%b exp=0", dsp_aclr); end
    n_checks++; if (dsp_accumulate !== 1'b1 || dsp_ax !== 8'h0) begin n_fail++;
      $display("FAIL bubble acc=%b ax=%h exp 1/00", dsp_accumulate, dsp_ax); end
    clear_logs();
  endtask

  task automatic test_vector4(input int gap);
    logic [7:0] v [4][4];
    v = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'd6, 8'd7, 8'd8},
          '{8'd2, 8'd2, 8'd2, 8'd2}, '{8'd0, 8'd9, 8'd9, 8'd0}};
    clear_logs();
    rdy_mode = 2'd1;
    for (int q = 0; q < 4; q++) begin
      drive_quad(v[q][0], v[q][1], v[q][2], v[q][3], q == 3);
      if (q == 1) repeat (gap) @(negedge clk0);
    end
    wait_results(1, 50);
    n_checks++; if (got_q.size() !== 1) begin n_fail++;
      $display("FAIL vec4_count gap=%0d got=%0d exp=1", gap, got_q.size()); end
    n_checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== 27'd108) begin n_fail++;
      $display("FAIL vec4_data gap=%0d got=%0d exp=108", gap, got_q.size() > 0 ? got_q[0] : 'x); end
    for (int q = 0; q < 4; q++) begin
      n_checks++; if ((acc_q.size() > q ? acc_q[q] : 1'bx) !== (q != 0)) begin n_fail++;
        $display("FAIL vec4_accumulate[%0d] got=%b exp=%b", q,
                 acc_q.size() > q ? acc_q[q] : 1'bx, q != 0); end
    end
    n_checks++;
    if (got_cyc.size() < 1 || acc_cyc.size() < 4 || got_cyc[0] - acc_cyc[3] != DSP_LAT + 1)
    begin n_fail++;
      $display("FAIL vec4_latency gap=%0d got=%0d exp=%0d", gap,
               (got_cyc.size() > 0 && acc_cyc.size() > 3) ? got_cyc[0] - acc_cyc[3] : -1,
               DSP_LAT + 1); end
  endtask

  task automatic test_single_b2b();
    clear_logs();
    rdy_mode = 2'd1;
    drive_quad(8'd10, 8'd10, 8'd1, 8'd1, 1'b1);
    drive_quad(8'd3, 8'd3, 8'd3, 8'd3, 1'b1);
    wait_results(2, 50);
    n_checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== 27'd101) begin n_fail++;
      $display("FAIL single_first got=%0d exp=101", got_q.size() > 0 ? got_q[0] : 'x); end
    n_checks++; if ((got_q.size() > 1 ? got_q[1] : 'x) !== 27'd18) begin n_fail++;
      $display("FAIL single_second got=%0d exp=18", got_q.size() > 1 ? got_q[1] : 'x); end
    n_checks++; if (acc_q.size() !== 2 || acc_q[0] !== 1'b0 || acc_q[1] !== 1'b0) begin
      n_fail++; $display("FAIL single_accumulate count=%0d exp two zeros", acc_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] op [3];
    logic [RES_W-1:0] exp_v [3];
    clear_logs();
    rdy_mode = 2'd0;
    for (int k = 0; k < 3; k++) begin
      op[k] = 8'($urandom);
      exp_v[k] = quad_prod(op[k], 8'd3, 8'd7, op[k]);
      drive_quad(op[k], 8'd3, 8'd7, op[k], 1'b1);
    end
    repeat (10) @(negedge clk0);
    n_checks++; if (bus.in_ready !== 1'b0 || dsp_ena !== 3'b000) begin n_fail++;
      $display("FAIL bp_stall in_ready=%b ena=%b exp 0/000", bus.in_ready, dsp_ena); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_v[0]) begin n_fail++;
      $display("FAIL bp_head valid=%b data=%0d exp 1/%0d", bus.out_valid, bus.out_data,
               exp_v[0]); end
    rdy_mode = 2'd1;
    wait_results(3, 100);
    n_checks++; if (got_q.size() !== 3) begin n_fail++;
      $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if ((got_q.size() > k ? got_q[k] : 'x) !== exp_v[k]) begin n_fail++;
        $display("FAIL bp_order[%0d] got=%0d exp=%0d", k,
                 got_q.size() > k ? got_q[k] : 'x, exp_v[k]); end
    end
  endtask

  task automatic test_random();
    logic [RES_W-1:0] exp_sum [$];
    logic             exp_acc [$];
    logic [RES_W-1:0] sum;
    logic [7:0]       a, b, c, d;
    int               len;
    clear_logs();
    rdy_mode = 2'd2;
    for (int v = 0; v < 8; v++) begin
      len = $urandom_range(1, 5);
      sum = '0;
      for (int q = 0; q < len; q++) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        sum = sum + quad_prod(a, b, c, d);
        exp_acc.push_back(q != 0);
        drive_quad(a, b, c, d, q == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk0);
      end
      exp_sum.push_back(sum);
    end
    wait_results(8, 400);
    rdy_mode = 2'd1;
    n_checks++; if (got_q.size() !== 8) begin n_fail++;
      $display("FAIL rand_count got=%0d exp=8", got_q.size()); end
    for (int v = 0; v < 8; v++) begin
      n_checks++; if ((got_q.size() > v ? got_q[v] : 'x) !== exp_sum[v]) begin n_fail++;
        $display("FAIL rand_sum[%0d] got=%0d exp=%0d", v,
                 got_q.size() > v ? got_q[v] : 'x, exp_sum[v]); end
    end
    n_checks++; if (acc_q !== exp_acc) begin n_fail++;
      $display("FAIL rand_accumulate got_len=%0d exp_len=%0d", acc_q.size(), exp_acc.size()); end
    n_checks++; if (drv_timeout !== 0) begin n_fail++;
      $display("FAIL drive_timeout got=%0d exp=0", drv_timeout); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    rdy_mode = 2'd0;
    drive_quad(8'd9, 8'd9, 8'd9, 8'd9, 1'b1);
    repeat (6) @(negedge clk0);
    drive_quad(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
    drive_quad(8'd6, 8'd6, 8'd6, 8'd6, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL mid_pre_valid got=%b exp=1", bus.out_valid); end
    #2 aclr0_n = 1'b0;
    #1;
    n_checks++; if (dsp_aclr !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL mid_async aclr=%b out_valid=%b exp 1/0", dsp_aclr, bus.out_valid); end
    @(negedge clk0);
    aclr0_n = 1'b1;
    rdy_mode = 2'd1;
    clear_logs();
    @(negedge clk0);
    drive_quad(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    wait_results(1, 50);
    repeat (4) @(negedge clk0);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 27'd2) begin n_fail++;
      $display("FAIL mid_after count=%0d data=%0d exp 1/2", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 'x); end
    n_checks++; if ((acc_q.size() > 0 ? acc_q[0] : 1'bx) !== 1'b0) begin n_fail++;
      $display("FAIL mid_accumulate got=%b exp=0", acc_q.size() > 0 ? acc_q[0] : 1'bx); end
  endtask

`ifdef DSP_MAC_SEQ_PERF_EN
  task automatic test_perf();
    int w = 0;
    aclr0_n = 1'b0;
    @(negedge clk0);
    aclr0_n = 1'b1;
    clear_logs();
    rdy_mode = 2'd0;
    drive_quad(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    drive_quad(8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
    while (bus.in_ready !== 1'b0 && w < 50) begin @(negedge clk0); w++; end
    bus.in_valid = 1'b1;
    bus.in_ax = 8'd5; bus.in_bx = 8'd5; bus.in_ay = 8'd5; bus.in_by = 8'd5;
    bus.in_last = 1'b1;
    repeat (4) @(negedge clk0);
    rdy_mode = 2'd1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin @(negedge clk0); w++; end
    @(negedge clk0);
    bus.in_valid = 1'b0;
    wait_results(3, 100);
    n_checks++; if (perf_stall_cnt !== 32'd5) begin n_fail++;
      $display("FAIL perf_stall got=%0d exp=5", perf_stall_cnt); end
    n_checks++; if (perf_vec_cnt !== 32'd3) begin n_fail++;
      $display("FAIL perf_vec got=%0d exp=3", perf_vec_cnt); end
    n_checks++; if ((got_q.size() > 2 ? got_q[2] : 'x) !== 27'd50) begin n_fail++;
      $display("FAIL perf_third got=%0d exp=50", got_q.size() > 2 ? got_q[2] : 'x); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    aclr0_n = 1'b0;
    rdy_mode = 2'd1;
    bus.in_valid = 1'b0;
    bus.in_ax = '0; bus.in_bx = '0; bus.in_ay = '0; bus.in_by = '0;
    bus.in_last = 1'b0;
    @(negedge clk0);
    test_reset();
    test_vector4(0);
    test_single_b2b();
    test_vector4(5);
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef DSP_MAC_SEQ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
